// File: rtl/instruction_decode_redirect.sv
// instruction_decode_redirect: IF/ID register with branch/jump redirect, wrong-path squash and perf counters
module instruction_decode_redirect #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instruction,
  input  logic [31:0]      NextInstruct,
  input  logic             Stall,
  input  logic [31:0]      RsData,
  input  logic [31:0]      RtData,
  output logic             PCWrite,
  output logic             Branch,
  output logic [31:0]      InstructOffset,
  output logic             Jump,
  output logic [25:0]      JumpInstruction,
  output logic [31:0]      IDInstruction,
  output logic [31:0]      IDNextInstruct,
  output logic             IDValid,
  output logic [CNT_W-1:0] RedirectCount,
  output logic [CNT_W-1:0] SquashCount
);
  typedef enum logic [1:0] {EMPTY, LIVE, SQUASH} state_t;
  state_t state, state_nxt;
  logic [5:0] opcode;
  logic is_beq, is_bne, is_jmp, redirect;
  assign opcode = IDInstruction[31:26];
  assign is_beq = opcode == 6'b000100;
  assign is_bne = opcode == 6'b000101;
  assign is_jmp = opcode == 6'b000010 || opcode == 6'b000011;
  assign InstructOffset = {{16{IDInstruction[15]}}, IDInstruction[15:0]};
  assign JumpInstruction = IDInstruction[25:0];
  // state register; reset drops any in-flight redirect immediately
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) state <= EMPTY;
    else state <= state_nxt;
  // redirect decode and next state; a stall freezes everything, including redirect
  always_comb begin
    PCWrite = ~Stall;
    IDValid = state == LIVE;
    Branch = IDValid & ~Stall & ((is_beq & (RsData == RtData)) | (is_bne & (RsData != RtData)));
    Jump = IDValid & ~Stall & is_jmp;
    redirect = Branch | Jump;
    state_nxt = Stall ? state : (redirect ? SQUASH : LIVE);
  end
  // IF/ID pipeline register, held while stalled
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      IDInstruction <= '0;
      IDNextInstruct <= '0;
    end else if (!Stall) begin
      IDInstruction <= Instruction;
      IDNextInstruct <= NextInstruct;
    end
  // saturating counters; every redirect squashes exactly one fetched slot
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      RedirectCount <= '0;
      SquashCount <= '0;
    end else if (redirect) begin
      RedirectCount <= &RedirectCount ? RedirectCount : RedirectCount + 1'b1;
      SquashCount <= &SquashCount ? SquashCount : SquashCount + 1'b1;
    end
endmodule

// File: doc/instruction_decode_redirect.md
# instruction_decode_redirect

Front half of the decode stage and the consumer side of the instruction-fetch interface. It latches each fetched `Instruction`/`NextInstruct` pair into an IF/ID register. It decodes `beq`/`bne`/`j`/`jal` in ID and drives the redirect inputs of the fetch unit (`Branch`, `Jump`, `InstructOffset`, `JumpInstruction`), squashing the wrong-path instruction that fetch supplies in the same cycle. It also gates the PC with `PCWrite` during hazard stalls and keeps saturating redirect/squash counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the redirect and squash counters

Ports:
- Clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low; 0 clears all state
- Instruction  in  32  instruction word from fetch for the current PC
- NextInstruct  in  32  PC+4 from fetch, paired with Instruction
- Stall  in  1  hazard-unit request to hold PC and IF/ID
- RsData  in  32  register-file read of ID rs field
- RtData  in  32  register-file read of ID rt field
- PCWrite  out  1  PC load enable to fetch; 0 freezes the PC
- Branch  out  1  taken-branch redirect to fetch
- InstructOffset  out  32  sign-extended imm16 of ID instruction (word offset, unshifted)
- Jump  out  1  jump redirect to fetch
- JumpInstruction  out  26  target field [25:0] of ID instruction
- IDInstruction  out  32  IF/ID instruction register
- IDNextInstruct  out  32  IF/ID PC+4 register
- IDValid  out  1  IDInstruction is architecturally live
- RedirectCount  out  CNT_W  taken branches plus jumps, saturating
- SquashCount  out  CNT_W  squashed wrong-path slots, saturating

## Operation
- FSM states:
  - EMPTY (reset state, IF/ID holds no live instruction)
  - LIVE (IF/ID holds a live instruction)
  - SQUASH (IF/ID holds a wrong-path instruction)
- Opcodes, from bits [31:26]:
  - beq = 6'b000100: taken when RsData == RtData
  - bne = 6'b000101: taken when RsData != RtData
  - j = 6'b000010
  - jal = 6'b000011
  - All other opcodes produce no redirect.
- Redirect (combinational):
  - Branch = IDValid & ~Stall & (beq|bne) & condition.
  - Jump = IDValid & ~Stall & (j|jal).
  - Branch and Jump are never both 1.
- InstructOffset = {{16{IDInstruction[15]}}, IDInstruction[15:0]}.
- JumpInstruction = IDInstruction[25:0].
- Both fields are driven from IDInstruction at all times, independent of IDValid.
- PCWrite = ~Stall.
- Each rising edge with Stall=0:
  - IF/ID loads Instruction/NextInstruct.
  - If Branch|Jump is asserted, next state is SQUASH, RedirectCount increments, and SquashCount increments.
  - Otherwise next state is LIVE.
- Rising edge with Stall=1:
  - IF/ID, state, and counters hold.
  - Redirect is suppressed; the branch re-evaluates once Stall drops, since operands may be stale.
- IDValid = (state == LIVE).
- EMPTY and SQUASH are bubbles: no redirect, downstream treats the slot as a nop.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, Reset=0):
  - State = EMPTY.
  - IDInstruction = 0 and IDNextInstruct = 0.
  - Counters = 0.
  - IDValid = 0, hence Branch = 0 and Jump = 0.
  - PCWrite follows Stall combinationally.
- Reset mid-operation: an in-flight redirect is dropped immediately; no counter update.
- First live instruction appears one edge after Reset rises, provided Stall=0.
- Redirect latency and no delay slot:
  - Cycle N: branch is in ID and Branch is high; fetch presents the PC+4 instruction.
  - Edge N→N+1: PC loads the target, and IF/ID captures the PC+4 instruction in SQUASH state.
  - Cycle N+1: IDValid = 0.
  - Cycle N+2: the target instruction is in ID and valid. Penalty is 1 bubble.
- Back-to-back redirects cannot occur; the slot after any redirect is always a bubble.
- Stall and a redirect condition in the same cycle: Stall wins, nothing changes.
- Stall asserted while in SQUASH: state holds SQUASH; the bubble persists until Stall drops.

## Test plan
- Reset and fill:
  - Stimulus: hold Reset=0 with random inputs, then release.
  - Response: all outputs 0 during reset (PCWrite = ~Stall); after the first edge, IDValid=1 and IDInstruction equals the sampled Instruction.
- Taken beq:
  - Stimulus: ID = 0x1022FFFC (beq, offset -4) with RsData = RtData = 5.
  - Response: Branch=1 and InstructOffset = 0xFFFFFFFC for one cycle; IDValid=0 in the next cycle; RedirectCount=1 and SquashCount=1.
- Not-taken bne:
  - Stimulus: ID = 0x14220003 with RsData = RtData = 7.
  - Response: Branch=0, no bubble, counters unchanged.
- Jump:
  - Stimulus: ID = 0x08000040.
  - Response: Jump=1, JumpInstruction = 0x0000040, following slot squashed.
- Stall priority:
  - Stimulus: taken beq in ID with Stall=1 for 3 cycles, then Stall=0.
  - Response: during the stall, PCWrite=0, Branch=0, and IF/ID is unchanged; Branch=1 on the first cycle after the stall; RedirectCount increments exactly once.
- Saturation and async reset:
  - Stimulus: preload the counters to 0xFFFE via repeated jumps, issue two more jumps, then assert Reset=0 mid-cycle while Jump=1.
  - Response: counters reach and stay at 0xFFFF; on Reset, outputs clear immediately without waiting for a clock edge.
